// File: rtl/crm_diag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crm_diag_pkg
// Description : Shared types and constants for the CRAM diagnostic load /
//               verify sequencer (state encoding, diag function bases,
//               address and slice-counter widths).
// Revision    : 1.0 - initial release
// ============================================================================
package crm_diag_pkg;

    // CRA address width
    localparam int C_ADR_W = 11;

    // Slice counter width; supports up to 32 slices per microword
    localparam int C_CNT_W = 5;

    // Diagnostic function bases; the slice number is added to these
    localparam logic [6:0] C_FUNC_LOAD_BASE = 7'o050;
    localparam logic [6:0] C_FUNC_READ_BASE = 7'o140;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADR      = 3'd1,
        ST_LOAD     = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_CHECK    = 3'd5,
        ST_DONE     = 3'd6
    } crm_state_e;

endpackage
`default_nettype wire

// File: rtl/crm_diag_chk.sv
`default_nettype none
// ============================================================================
// Module      : crm_diag_chk
// Description : Read-back checker. On each capture strobe compares the read
//               nibble with the expected nibble (sticky error) and folds the
//               read nibble into a running single-bit XOR parity.
// Revision    : 1.0 - initial release
// ============================================================================
module crm_diag_chk (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cap,
    input  logic       i_clr,
    input  logic [3:0] i_exp_nib,
    input  logic [3:0] i_rd_nib,
    output logic       o_cmp_err,
    output logic       o_par
);

    logic cmp_err_q, cmp_err_d;
    logic par_q,     par_d;

    // Next-state: clear wins over capture; the compare error is sticky
    always_comb begin
        cmp_err_d = cmp_err_q;
        par_d     = par_q;
        if (i_clr) begin
            cmp_err_d = 1'b0;
            par_d     = 1'b0;
        end else if (i_cap) begin
            cmp_err_d = cmp_err_q | (i_rd_nib != i_exp_nib);
            par_d     = par_q ^ (^i_rd_nib);
        end
    end

    // Checker state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_err_q <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            cmp_err_q <= cmp_err_d;
            par_q     <= par_d;
        end
    end

    assign o_cmp_err = cmp_err_q;
    assign o_par     = par_q;

endmodule
`default_nettype wire

// File: rtl/crm_diag_seq.sv
`default_nettype none
// ============================================================================
// Module      : crm_diag_seq
// Description : CRAM diagnostic sequencer. Optionally loads an N_SLICE x 4-bit
//               microword slice by slice through the diag load functions,
//               then reads every slice back, compares it and checks the CRAM
//               parity chain (odd parity). Reports via done/err flags.
// Revision    : 1.0 - initial release
// ============================================================================
module crm_diag_seq
    import crm_diag_pkg::*;
#(
    parameter int N_SLICE = 21,
    parameter int RD_LAT  = 2
) (
    input  logic                   clk_crm_h,
    input  logic                   mr_reset_h,
    input  logic                   req_h,
    input  logic                   req_verify_h,
    input  logic [C_ADR_W-1:0]     req_adr_h,
    input  logic [4*N_SLICE-1:0]   req_word_h,
    output logic                   busy_h,
    output logic                   done_h,
    output logic                   err_cmp_h,
    output logic                   err_par_h,
    output logic [C_ADR_W-1:0]     cra_adr_h,
    output logic [6:0]             diag_func_h,
    output logic                   diag_load_h,
    output logic                   diag_read_h,
    output logic [3:0]             diag_wdata_h,
    input  logic [3:0]             ebus_rdata_h,
    input  logic                   cram_par_h
);

    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(N_SLICE - 1);
    localparam logic [7:0]         C_LAT  = 8'(RD_LAT);

    crm_state_e                 state_q, state_d;
    logic [C_ADR_W-1:0]         adr_q,   adr_d;
    logic [4*N_SLICE-1:0]       word_q,  word_d;
    logic [C_CNT_W-1:0]         k_q,     k_d;
    logic [7:0]                 wait_q,  wait_d;
    logic                       err_par_q, err_par_d;

    logic                       w_cap;
    logic                       w_clr;
    logic                       w_cmp_err;
    logic                       w_par;
    logic [3:0]                 w_slice;
    logic                       w_last;

    assign w_slice = word_q[{k_q, 2'b00} +: 4];
    assign w_last  = (k_q == C_LAST);

    // Next-state and strobe/output decode; every output defaults to idle
    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        word_d       = word_q;
        k_d          = k_q;
        wait_d       = wait_q;
        err_par_d    = err_par_q;
        busy_h       = 1'b1;
        done_h       = 1'b0;
        cra_adr_h    = adr_q;
        diag_func_h  = 7'd0;
        diag_load_h  = 1'b0;
        diag_read_h  = 1'b0;
        diag_wdata_h = 4'd0;
        w_cap        = 1'b0;
        w_clr        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_h    = 1'b0;
                cra_adr_h = '0;
                if (req_h) begin
                    adr_d     = req_adr_h;
                    word_d    = req_word_h;
                    k_d       = '0;
                    wait_d    = '0;
                    err_par_d = 1'b0;
                    w_clr     = 1'b1;
                    state_d   = ST_ADR;
                end
            end
            ST_ADR: begin
                state_d = req_verify_h ? ST_RD_ISSUE : ST_LOAD;
            end
            ST_LOAD: begin
                diag_load_h  = 1'b1;
                diag_func_h  = C_FUNC_LOAD_BASE + {2'b00, k_q};
                diag_wdata_h = w_slice;
                if (w_last) begin
                    k_d     = '0;
                    state_d = ST_RD_ISSUE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_RD_ISSUE: begin
                diag_read_h = 1'b1;
                diag_func_h = C_FUNC_READ_BASE + {2'b00, k_q};
                // With zero latency the data is already on the bus this cycle
                if (RD_LAT == 0) begin
                    w_cap = 1'b1;
                end else begin
                    wait_d  = 8'd1;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == C_LAT) begin
                    w_cap = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_CHECK: begin
                err_par_d = err_par_q | (cram_par_h != (w_par ^ 1'b1));
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                // busy stays up through this cycle; it drops as we re-enter IDLE
                done_h  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A captured slice advances the read loop
        if (w_cap) begin
            if (w_last) begin
                k_d     = '0;
                state_d = ST_CHECK;
            end else begin
                k_d     = k_q + 1'b1;
                state_d = ST_RD_ISSUE;
            end
        end
    end

    // State and datapath registers; reset aborts any sequence in flight
    always_ff @(posedge clk_crm_h or posedge mr_reset_h) begin
        if (mr_reset_h) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            word_q    <= '0;
            k_q       <= '0;
            wait_q    <= '0;
            err_par_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            word_q    <= word_d;
            k_q       <= k_d;
            wait_q    <= wait_d;
            err_par_q <= err_par_d;
        end
    end

    crm_diag_chk u_chk (
        .clk       (clk_crm_h),
        .rst       (mr_reset_h),
        .i_cap     (w_cap),
        .i_clr     (w_clr),
        .i_exp_nib (w_slice),
        .i_rd_nib  (ebus_rdata_h),
        .o_cmp_err (w_cmp_err),
        .o_par     (w_par)
    );

    assign err_cmp_h = w_cmp_err;
    assign err_par_h = err_par_q;

endmodule
`default_nettype wire

// File: tb/tb_crm_diag_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_crm_diag_seq
// Description : Scoreboard bench for crm_diag_seq. Three independent lanes
//               run the sequencer built with RD_LAT = 0, 2 and 3 against a
//               behavioural CRAM model (read-back array + parity chain).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crm_diag_seq;

    localparam int N = 21;

    typedef struct {
        logic         ecmp;
        logic         epar;
        int           nload;
        int           nread;
        int           busy;
        logic [10:0]  adr;
        logic [83:0]  word;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_err     = 0;
    int lanes_fin = 0;

    function automatic void chk(input int lane, input string nm,
                                input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL lane%0d %s: got %0h expected %0h", lane, nm, act, exp);
        end
    endfunction

    for (genvar l = 0; l < 3; l++) begin : g_lane
        localparam int LAT = (l == 0) ? 0 : ((l == 1) ? 2 : 3);

        logic        rst = 1'b1;
        logic        req = 1'b0;
        logic        ver = 1'b0;
        logic [10:0] adr = '0;
        logic [83:0] word = '0;
        logic        busy, done, ecmp, epar, ld, rd, cpar;
        logic [10:0] cra;
        logic [6:0]  func;
        logic [3:0]  wd, ebus;
        logic [3:0]  junk = 4'd0;
        logic [3:0]  rb [0:31];
        logic        par_flip = 1'b0;
        logic [5:0]  pipe [0:3];
        logic [5:0]  sel;
        exp_t        q[$];

        crm_diag_seq #(.N_SLICE(N), .RD_LAT(LAT)) u_dut (
            .clk_crm_h    (clk),
            .mr_reset_h   (rst),
            .req_h        (req),
            .req_verify_h (ver),
            .req_adr_h    (adr),
            .req_word_h   (word),
            .busy_h       (busy),
            .done_h       (done),
            .err_cmp_h    (ecmp),
            .err_par_h    (epar),
            .cra_adr_h    (cra),
            .diag_func_h  (func),
            .diag_load_h  (ld),
            .diag_read_h  (rd),
            .diag_wdata_h (wd),
            .ebus_rdata_h (ebus),
            .cram_par_h   (cpar)
        );

        // CRAM read model: a read of slice k returns rb[k] exactly LAT cycles later
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= {rd, 5'(func - 7'o140)};
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
            end
        end
        always @(negedge clk) junk <= 4'($urandom);
        assign sel  = (LAT == 0) ? {rd, 5'(func - 7'o140)} : pipe[(LAT == 0) ? 0 : LAT - 1];
        assign ebus = sel[5] ? rb[sel[4:0]] : junk;

        // Parity chain: odd parity over what the array holds, optionally corrupted
        always_comb begin
            cpar = 1'b1 ^ par_flip;
            for (int k = 0; k < N; k++) cpar = cpar ^ (^rb[k]);
        end

        // Monitor: checks strobes every cycle and scores each done against the queue
        initial begin
            int   li, ri, bc;
            logic pd;
            exp_t e;
            li = 0; ri = 0; bc = 0; pd = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    li = 0; ri = 0; bc = 0; pd = 1'b0;
                end else begin
                    if (busy) bc++;
                    if (busy && q.size() > 0) chk(l, "cra_adr", cra, q[0].adr);
                    if (ld) begin
                        if (q.size() > 0 && li < N) begin
                            chk(l, "load_func", func, 7'o050 + 7'(li));
                            chk(l, "load_wdata", wd, q[0].word[4*li +: 4]);
                        end
                        li++;
                    end
                    if (rd) begin
                        if (q.size() > 0) chk(l, "read_func", func, 7'o140 + 7'(ri));
                        ri++;
                    end
                    if (!ld && !rd) chk(l, "func_wdata_idle", {func, wd}, 0);
                    if (done) begin
                        chk(l, "done_width", pd, 0);
                        if (q.size() == 0) begin
                            chk(l, "spurious_done", 1, 0);
                        end else begin
                            e = q.pop_front();
                            chk(l, "n_load", li, e.nload);
                            chk(l, "n_read", ri, e.nread);
                            chk(l, "busy_cycles", bc, e.busy);
                            chk(l, "err_cmp", ecmp, e.ecmp);
                            chk(l, "err_par", epar, e.epar);
                        end
                        li = 0; ri = 0; bc = 0;
                    end
                    pd = done;
                end
            end
        end

        task automatic set_array(input logic [83:0] w, input int bad, input logic [3:0] bv,
                                 input logic pf, output logic mis);
            mis = 1'b0;
            for (int k = 0; k < 32; k++) rb[k] = 4'd0;
            for (int k = 0; k < N; k++) begin
                rb[k] = w[4*k +: 4];
                if (k == bad) begin
                    rb[k] = bv;
                    if (bv != w[4*k +: 4]) mis = 1'b1;
                end
            end
            par_flip = pf;
        endtask

        // One full sequence, started on a negedge with the DUT idle
        task automatic run_seq(input logic v, input logic hold, input int bad,
                               input logic [3:0] bv, input logic pf,
                               input logic [83:0] w, input logic [10:0] a);
            exp_t e;
            logic mis;
            bit   got;
            set_array(w, bad, bv, pf, mis);
            e.ecmp  = mis;
            e.epar  = pf;
            e.nload = v ? 0 : N;
            e.nread = N;
            e.busy  = 1 + e.nload + N * (1 + LAT) + 2;
            e.adr   = a;
            e.word  = w;
            q.push_back(e);
            req = 1'b1; ver = v; adr = a; word = w;
            @(negedge clk);
            chk(l, "accept", busy, 1);
            if (!hold) req = 1'b0;
            adr  = 11'($urandom);
            word = 84'({$urandom(), $urandom(), $urandom()});
            got = 0;
            for (int c = 0; c < 1000 && !got; c++) begin
                @(negedge clk);
                if (done) got = 1;
            end
            if (!got) chk(l, "done_timeout", 0, 1);
            @(negedge clk);
            req = 1'b0;
            chk(l, "idle_after_done", busy, 0);
            @(negedge clk);
            chk(l, "no_restart", busy, 0);
        endtask

        // Start a load, then hit reset during the slice-10 read wait
        task automatic abort_seq(input logic [83:0] w);
            logic mis;
            bit   got;
            set_array(w, -1, 4'd0, 1'b0, mis);
            req = 1'b1; ver = 1'b0; adr = 11'o777; word = w;
            @(negedge clk);
            req = 1'b0;
            got = 0;
            for (int c = 0; c < 1000 && !got; c++) begin
                @(negedge clk);
                if (rd && func == 7'o152) got = 1;
            end
            if (!got) chk(l, "abort_reach_timeout", 0, 1);
            if (LAT > 0) @(posedge clk);
            #2 rst = 1'b1;
            #1 chk(l, "abort_outs_zero",
                   {busy, done, ecmp, epar, cra, func, ld, rd, wd}, 0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
        endtask

        // Lane stimulus
        initial begin
            logic [83:0] w;
            logic [83:0] w7;
            repeat (3) @(negedge clk);
            chk(l, "reset_outs", {busy, done, ecmp, epar, cra, func, ld, rd, wd}, 0);
            rst = 1'b0;
            @(negedge clk);
            chk(l, "post_reset_idle", {busy, done, ecmp, epar}, 0);

            run_seq(1'b0, 1'b0, -1, 4'd0, 1'b0, {84{1'b1}}, 11'o1234);
            w7 = 84'({$urandom(), $urandom(), $urandom()});
            w7[28 +: 4] = 4'h5;
            run_seq(1'b1, 1'b0, 7, 4'hA, 1'b0, w7, 11'o0007);
            w = 84'({$urandom(), $urandom(), $urandom()});
            run_seq(1'b0, 1'b0, -1, 4'd0, 1'b1, w, 11'o2525);
            abort_seq(84'({$urandom(), $urandom(), $urandom()}));
            w = 84'({$urandom(), $urandom(), $urandom()});
            run_seq(1'b0, 1'b0, -1, 4'd0, 1'b0, w, 11'o0001);
            w = 84'({$urandom(), $urandom(), $urandom()});
            run_seq(1'b0, 1'b1, -1, 4'd0, 1'b0, w, 11'o3777);
            for (int i = 0; i < 8; i++) begin
                w = 84'({$urandom(), $urandom(), $urandom()});
                run_seq(1'($urandom_range(0, 1)), 1'b0,
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                        4'($urandom), 1'($urandom_range(0, 1)), w, 11'($urandom));
            end
            chk(l, "queue_drained", q.size(), 0);
            lanes_fin++;
        end
    end

    initial begin
        for (int c = 0; c < 50000 && lanes_fin < 3; c++) @(negedge clk);
        if (lanes_fin < 3) begin
            n_checks++;
            n_err++;
            $display("FAIL global_timeout: lanes finished %0d expected 3", lanes_fin);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
